// File: rtl/mem_access_pkg.sv
// Shared types and defaults for the load/store memory access controller.
package mem_access_pkg;

  localparam int unsigned DEFAULT_DATA_MEM_SIZE = 4000;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR_ARM,
    WR_COMMIT,
    RESP
  } state_e;

endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane extract (loads) and merge (read-modify-write stores).
//   word     : memory word being read
//   size     : access size encoding
//   lane     : byte offset within the word (addr[1:0])
//   sign_ext : sign-extend sub-word load data
//   wdata    : right-aligned store data
//   rdata    : right-aligned, extended load result
//   merged   : word with the addressed lanes replaced by wdata
module mem_lane_unit
  import mem_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic [4:0]  sh;
  logic [31:0] shifted;
  logic [31:0] mask;

  always_comb begin
    sh      = {lane, 3'b000};
    shifted = word >> sh;
    rdata   = '0;
    mask    = '0;
    case (size_e'(size))
      SIZE_BYTE: begin
        rdata = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
        mask  = 32'h0000_00FF << sh;
      end
      SIZE_HALF: begin
        rdata = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
        mask  = 32'h0000_FFFF << sh;
      end
      SIZE_WORD: begin
        rdata = shifted;
        mask  = '1;
      end
      default: ;
    endcase
    merged = (word & ~mask) | ((wdata << sh) & mask);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller between a pipeline request port and a word memory.
//   clk, rst                    : clock, async active-high reset
//   req_*                       : request handshake and fields
//   resp_valid/rdata/error      : one-cycle completion
//   mem_address/read/write/wdata, mem_rdata : word memory port
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int unsigned DATA_MEM_SIZE = DEFAULT_DATA_MEM_SIZE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_e      state;
  logic        write_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [1:0]  lane_q;
  logic [31:0] wdata_q;
  logic        req_err;
  logic [31:0] lane_rdata;
  logic [31:0] lane_merged;

  always_comb begin
    req_err = 1'b0;
    case (size_e'(req_size))
      SIZE_BYTE: req_err = 1'b0;
      SIZE_HALF: req_err = req_addr[0];
      SIZE_WORD: req_err = |req_addr[1:0];
      default:   req_err = 1'b1;
    endcase
    if ({2'b00, req_addr[31:2]} >= DATA_MEM_SIZE) req_err = 1'b1;
  end

  // Operates on the live memory word during RD; the result is registered
  // at the end of RD into either resp_rdata (load) or mem_wdata (RMW).
  mem_lane_unit u_lane (
    .word     (mem_rdata),
    .size     (size_q),
    .lane     (lane_q),
    .sign_ext (signed_q),
    .wdata    (wdata_q),
    .rdata    (lane_rdata),
    .merged   (lane_merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_error  <= 1'b0;
      mem_address <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_wdata   <= '0;
      write_q     <= 1'b0;
      size_q      <= '0;
      signed_q    <= 1'b0;
      lane_q      <= '0;
      wdata_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            write_q   <= req_write;
            size_q    <= req_size;
            signed_q  <= req_signed;
            lane_q    <= req_addr[1:0];
            wdata_q   <= req_wdata;
            if (req_err) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= '0;
            end else if (!req_write || (req_size != SIZE_WORD)) begin
              state       <= RD;
              mem_read    <= 1'b1;
              mem_address <= {2'b00, req_addr[31:2]};
            end else begin
              state       <= WR_ARM;
              mem_write   <= 1'b1;
              mem_address <= {2'b00, req_addr[31:2]};
              mem_wdata   <= req_wdata;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        RD: begin
          mem_read <= 1'b0;
          if (write_q) begin
            state     <= WR_ARM;
            mem_write <= 1'b1;
            mem_wdata <= lane_merged;
          end else begin
            state       <= RESP;
            mem_address <= '0;
            resp_valid  <= 1'b1;
            resp_rdata  <= lane_rdata;
          end
        end
        WR_ARM: begin
          state <= WR_COMMIT;
        end
        WR_COMMIT: begin
          state       <= RESP;
          mem_write   <= 1'b0;
          mem_address <= '0;
          mem_wdata   <= '0;
          resp_valid  <= 1'b1;
          resp_rdata  <= '0;
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_access_ctrl #(.DATA_MEM_SIZE(4000)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_error  (resp_error),
    .mem_address (mem_address),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // Memory model: combinational read, commit on the second consecutive
  // mem_write cycle.
  logic [31:0] mem [4096];
  logic        wr_armed = 1'b0;

  assign mem_rdata = (mem_read && mem_address < 32'd4096) ? mem[mem_address[11:0]] : '0;

  always @(posedge clk) begin
    if (mem_write && wr_armed && mem_address < 32'd4096) mem[mem_address[11:0]] <= mem_wdata;
    wr_armed <= mem_write;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("rd_wr_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
      if (!mem_read && !mem_write) begin
        chk("idle_addr_zero", mem_address, 32'd0);
        chk("idle_wdata_zero", mem_wdata, 32'd0);
      end
    end
  end

  task automatic pop_check(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, {31'b0, sb.size() != 0}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, resp_rdata, e.rdata);
      chk({tag, "_error"}, {31'b0, resp_error}, {31'b0, e.err});
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd,
                        input logic e, input int exp_lat, input int exp_rdc, input int exp_wrc);
    int lat = 0;
    int rdc = 0;
    int wrc = 0;
    logic [31:0] wd_first = '0;
    exp_t x;
    wait_ready();
    req_valid  = 1'b1;
    req_write  = w;
    req_size   = sz;
    req_signed = sg;
    req_addr   = a;
    req_wdata  = wd;
    x.rdata = exp_rd;
    x.err   = e;
    sb.push_back(x);
    @(posedge clk);
    #1;
    // Scramble fields after acceptance; they must not matter.
    req_valid  = 1'b0;
    req_write  = ~w;
    req_size   = ~sz;
    req_signed = ~sg;
    req_addr   = ~a;
    req_wdata  = ~wd;
    do begin
      @(negedge clk);
      lat++;
      if (mem_read) begin
        rdc++;
        chk({tag, "_rd_addr"}, mem_address, {2'b00, a[31:2]});
      end
      if (mem_write) begin
        wrc++;
        chk({tag, "_wr_addr"}, mem_address, {2'b00, a[31:2]});
        if (wrc == 1) wd_first = mem_wdata;
        else chk({tag, "_wdata_stable"}, mem_wdata, wd_first);
      end
      chk({tag, "_ready_busy"}, {31'b0, req_ready}, 32'd0);
    end while (!resp_valid && lat < 10);
    chk({tag, "_resp_seen"}, {31'b0, resp_valid}, 32'd1);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_rd_cycles"}, rdc, exp_rdc);
    chk({tag, "_wr_cycles"}, wrc, exp_wrc);
    if (resp_valid) pop_check(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int rsp;
    int seen;
    exp_t x;

    rst = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = 2'b00;
    req_signed = 1'b0;
    req_addr = '0;
    req_wdata = '0;
    #2;
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_mem_rw", {30'b0, mem_read, mem_write}, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_ready_low", {31'b0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("post_rst_ready_high", {31'b0, req_ready}, 32'd1);

    // Word store then load.
    do_req("sw_deadbeef", 1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, 32'h0, 1'b0, 3, 0, 2);
    do_req("lw_deadbeef", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0);

    // Byte read-modify-write and sub-word loads.
    do_req("sw_11223344", 1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344, 32'h0, 1'b0, 3, 0, 2);
    do_req("sb_aa", 1'b1, 2'b00, 1'b0, 32'h41, 32'h555555AA, 32'h0, 1'b0, 4, 1, 2);
    do_req("lw_after_sb", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h1122AA44, 1'b0, 2, 1, 0);
    do_req("lb_41", 1'b0, 2'b00, 1'b1, 32'h41, 32'h0, 32'hFFFFFFAA, 1'b0, 2, 1, 0);
    do_req("lbu_41", 1'b0, 2'b00, 1'b0, 32'h41, 32'h0, 32'h000000AA, 1'b0, 2, 1, 0);
    do_req("lbu_43", 1'b0, 2'b00, 1'b0, 32'h43, 32'h0, 32'h00000011, 1'b0, 2, 1, 0);
    do_req("lh_40", 1'b0, 2'b01, 1'b1, 32'h40, 32'h0, 32'hFFFFAA44, 1'b0, 2, 1, 0);
    do_req("sh_42", 1'b1, 2'b01, 1'b0, 32'h42, 32'h1234BEEF, 32'h0, 1'b0, 4, 1, 2);
    do_req("lw_after_sh", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'hBEEFAA44, 1'b0, 2, 1, 0);

    // Half-word load with sign extension.
    do_req("sw_8001ffff", 1'b1, 2'b10, 1'b0, 32'h40, 32'h8001FFFF, 32'h0, 1'b0, 3, 0, 2);
    do_req("lh_42", 1'b0, 2'b01, 1'b1, 32'h42, 32'h0, 32'hFFFF8001, 1'b0, 2, 1, 0);
    do_req("lhu_42", 1'b0, 2'b01, 1'b0, 32'h42, 32'h0, 32'h00008001, 1'b0, 2, 1, 0);

    // Last valid word.
    do_req("sw_last", 1'b1, 2'b10, 1'b0, 32'h3E7C, 32'hCAFEF00D, 32'h0, 1'b0, 3, 0, 2);
    do_req("lw_last", 1'b0, 2'b10, 1'b0, 32'h3E7C, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1, 0);

    // Rejected requests.
    do_req("err_lw_42", 1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("err_lh_43", 1'b0, 2'b01, 1'b0, 32'h43, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("err_lw_range", 1'b0, 2'b10, 1'b0, 32'h3E80, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("err_sb_range", 1'b1, 2'b00, 1'b0, 32'h3E80, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("err_rsvd", 1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1, 1, 0, 0);
    do_req("err_sw_42", 1'b1, 2'b10, 1'b0, 32'h42, 32'h99999999, 32'h0, 1'b1, 1, 0, 0);
    do_req("lw_after_err", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h8001FFFF, 1'b0, 2, 1, 0);

    // Reset during the first mem_write cycle of a word store.
    wait_ready();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size = 2'b10;
    req_addr = 32'h40;
    req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("abort_wr_armed", {31'b0, mem_write}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_mem_write_drop", {31'b0, mem_write}, 32'd0);
    chk("abort_mem_address_drop", mem_address, 32'd0);
    chk("abort_mem_wdata_drop", mem_wdata, 32'd0);
    chk("abort_ready_drop", {31'b0, req_ready}, 32'd0);
    seen = 0;
    @(negedge clk);
    if (resp_valid) seen++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("abort_no_resp", seen, 0);
    do_req("lw_after_abort", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h8001FFFF, 1'b0, 2, 1, 0);

    // req_valid held for 10 cycles: one acceptance per IDLE visit.
    wait_ready();
    req_valid = 1'b1;
    req_write = 1'b0;
    req_size = 2'b10;
    req_signed = 1'b0;
    req_addr = 32'h40;
    acc = 0;
    rsp = 0;
    for (int i = 0; i < 10; i++) begin
      chk("held_ready_pattern", {31'b0, req_ready}, {31'b0, (i % 3) == 0});
      if (req_ready) begin
        acc++;
        x.rdata = 32'h8001FFFF;
        x.err = 1'b0;
        sb.push_back(x);
      end
      if (resp_valid) begin
        rsp++;
        chk("held_ready_in_resp", {31'b0, req_ready}, 32'd0);
        pop_check("held");
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid) begin
        rsp++;
        pop_check("held_tail");
      end
      @(negedge clk);
    end
    chk("held_accepts", acc, 4);
    chk("held_responses", rsp, 4);
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: DATA_MEM_SIZE, 4000, number of 32-bit words in the attached data memory.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req_valid  input  1  pipeline load/store request present.
REQ-005 req_ready  output  1  controller can accept a request.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 req_signed  input  1  sign-extend sub-word load data.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  load result, extended per req_signed.
REQ-013 resp_error  output  1  request rejected (misaligned, out of range or reserved size).
REQ-014 mem_address  output  32  word index to memory (req_addr >> 2).
REQ-015 mem_read  output  1  memory read enable.
REQ-016 mem_write  output  1  memory write enable.
REQ-017 mem_wdata  output  32  memory write data.
REQ-018 mem_rdata  input  32  memory read data; valid while mem_read is high.

Function
REQ-019 The FSM states SHALL be IDLE, RD, WR_ARM, WR_COMMIT and RESP.
REQ-020 req_ready SHALL be 1 only in IDLE.
- A request is accepted on a rising edge when req_valid and req_ready are both 1.
- All request fields are registered at acceptance.
REQ-021 Error check at acceptance SHALL be:
- reserved size;
- half with addr[0] = 1;
- word with addr[1:0] != 0;
- word index >= DATA_MEM_SIZE.
Any failure SHALL go IDLE->RESP with resp_error = 1, resp_rdata = 0, and no mem_read or mem_write.
REQ-022 Load: the FSM SHALL go IDLE->RD->RESP.
- mem_read = 1 for exactly the RD cycle.
- mem_rdata is captured at the end of RD.
- resp_valid is high in the next cycle, so read latency is 2 cycles from acceptance.
REQ-023 Byte lane k = addr[1:0], bits [8k+7:8k], little-endian; a half uses lanes k and k+1.
- Extraction is right-aligned.
- Zero-extend when req_signed = 0, sign-extend when req_signed = 1.
REQ-024 Word store: the FSM SHALL go IDLE->WR_ARM->WR_COMMIT->RESP.
- mem_write = 1 for exactly those two consecutive cycles.
- mem_address and mem_wdata are constant across both cycles.
- The memory commits on the second asserted cycle.
REQ-025 Byte/half store SHALL be read-modify-write: IDLE->RD->WR_ARM->WR_COMMIT->RESP.
- The captured word is merged with req_wdata low bits in the addressed lanes only.
- Other lanes are preserved bit-exact.
REQ-026 mem_read and mem_write SHALL never be high in the same cycle.
REQ-027 mem_write SHALL be low for at least one cycle between any two stores.
REQ-028 Outside RD/WR_ARM/WR_COMMIT, the outputs SHALL be:
- mem_read = 0, mem_write = 0;
- mem_address = 0, mem_wdata = 0.
REQ-029 resp_valid SHALL be high only in RESP (one cycle) and SHALL not be back-pressured.
- resp_rdata and resp_error are valid only while resp_valid is high.
- For stores, resp_rdata = 0.
REQ-030 RESP SHALL always return to IDLE, so back-to-back requests are separated by at least one idle cycle.
REQ-031 req_valid SHALL be ignored in all states except IDLE, and request-field changes after acceptance SHALL have no effect.

Reset
REQ-032 When rst is asserted, the controller SHALL immediately (asynchronously) return to IDLE and drive all outputs to 0.
- req_ready becomes 1 on the first edge after rst deasserts.
REQ-033 A reset mid-operation SHALL abandon the transfer with no resp_valid.
- A store abandoned in WR_ARM produces no commit.

Structure
REQ-034 Package mem_access_pkg SHALL hold:
- the size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD);
- the FSM state type;
- the DATA_MEM_SIZE default.
REQ-035 Lane extract/merge logic SHALL be one combinational sub-module, mem_lane_unit. The FSM and registers stay in mem_access_ctrl.

Verification
REQ-036 Word store then load: store 0xDEADBEEF at 0x40, then load word at 0x40.
- Store: mem_write is high for 2 cycles with mem_address = 16.
- Load: resp_rdata = 0xDEADBEEF, 2 cycles after acceptance.
REQ-037 Byte RMW: word 16 = 0x11223344; store byte 0xAA at 0x41.
- Memory then holds 0x1122AA44.
- lb at 0x41 -> 0xFFFFFFAA; lbu at 0x41 -> 0x000000AA.
REQ-038 Half-word load: lh at 0x42 with word 16 = 0x8001FFFF -> 0xFFFF8001.
REQ-039 Errors, each giving resp_error = 1 with mem_read and mem_write never asserted:
- word load at 0x42;
- half load at 0x43;
- word at byte address 4*4000;
- req_size = 11.
REQ-040 Reset in WR_ARM: assert rst during the first mem_write cycle.
- Outputs drop within the same cycle.
- No resp_valid.
- A subsequent load of that word returns the old value.
REQ-041 Held req_valid: keep req_valid high for 10 cycles with loads.
- Exactly one acceptance per IDLE visit.
- req_ready is low during RD and RESP.
